// File: rtl/pipelined_mul_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mul_unit_if
// Brief    : Issue/retire handshake bundle for the pipelined multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_mul_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    // Producer/consumer side.
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Multiplier side.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mul_unit
// Brief    : Fully pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU),
//            retiring BITS_PER_STAGE multiplier bits per registered stage.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_mul_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipelined_mul_unit_if.slave  bus
);

    localparam int c_stages = WIDTH / BITS_PER_STAGE;
    localparam int c_last   = c_stages - 1;
    localparam int c_ext_w  = WIDTH + 1;
    localparam int c_acc_w  = 2 * WIDTH + 2;

    localparam logic [1:0] c_op_mul    = 2'b00;
    localparam logic [1:0] c_op_mulh   = 2'b01;
    localparam logic [1:0] c_op_mulhsu = 2'b10;

    typedef logic signed [c_acc_w-1:0] acc_t;
    typedef logic        [c_ext_w-1:0] ext_t;

    function automatic acc_t widen(input ext_t v);
        return acc_t'({{(c_acc_w - c_ext_w){v[c_ext_w-1]}}, v});
    endfunction

    // Sum of a * 2^(shift+j) for every set bit j of the multiplier slice.
    function automatic acc_t chunk_sum(
        input ext_t                      a,
        input logic [BITS_PER_STAGE-1:0] bits,
        input int                        shift
    );
        acc_t a_w;
        acc_t sum;
        a_w = widen(a);
        sum = '0;
        for (int j = 0; j < BITS_PER_STAGE; j++) begin
            if (bits[j]) begin
                sum = sum + (a_w <<< (shift + j));
            end
        end
        return sum;
    endfunction

    // Stage registers
    logic [c_stages-1:0] r_valid;
    acc_t                r_acc [c_stages];
    ext_t                r_a   [c_stages];
    ext_t                r_b   [c_stages];
    logic [1:0]          r_op  [c_stages];
    logic [TAG_W-1:0]    r_tag [c_stages];

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_result;
    logic [TAG_W-1:0]    r_out_tag;

    // Combinational
    logic                w_advance;
    logic                w_accept;
    logic                w_a_signed;
    logic                w_b_signed;
    ext_t                w_a_ext;
    ext_t                w_b_ext;
    acc_t                w_src_acc [c_stages];
    ext_t                w_src_a   [c_stages];
    ext_t                w_src_b   [c_stages];
    logic [1:0]          w_src_op  [c_stages];
    logic [TAG_W-1:0]    w_src_tag [c_stages];
    acc_t                w_acc_nxt [c_stages];
    acc_t                w_product;
    logic [WIDTH-1:0]    w_result_sel;
    logic                w_unused_product_hi;

    assign w_advance = !r_out_valid || bus.out_ready;
    assign w_accept  = bus.in_valid && w_advance && !flush;

    assign w_a_signed = (bus.in_op == c_op_mulh) || (bus.in_op == c_op_mulhsu);
    assign w_b_signed = (bus.in_op == c_op_mulh);
    assign w_a_ext    = {w_a_signed && bus.in_a[WIDTH-1], bus.in_a};
    assign w_b_ext    = {w_b_signed && bus.in_b[WIDTH-1], bus.in_b};

    // Each stage's inputs: the issue port for stage 0, the previous stage otherwise.
    always_comb begin
        for (int s = 0; s < c_stages; s++) begin
            w_src_acc[s] = '0;
            w_src_a[s]   = w_a_ext;
            w_src_b[s]   = w_b_ext;
            w_src_op[s]  = bus.in_op;
            w_src_tag[s] = bus.in_tag;
        end
        for (int s = 1; s < c_stages; s++) begin
            w_src_acc[s] = r_acc[s-1];
            w_src_a[s]   = r_a[s-1];
            w_src_b[s]   = r_b[s-1];
            w_src_op[s]  = r_op[s-1];
            w_src_tag[s] = r_tag[s-1];
        end
    end

    always_comb begin
        for (int s = 0; s < c_stages; s++) begin
            w_acc_nxt[s] = w_src_acc[s]
                         + chunk_sum(w_src_a[s],
                                     w_src_b[s][s*BITS_PER_STAGE +: BITS_PER_STAGE],
                                     s * BITS_PER_STAGE);
        end
        // Extended-b top bit carries weight -2^WIDTH.
        if (w_src_b[c_last][WIDTH]) begin
            w_acc_nxt[c_last] = w_acc_nxt[c_last] - (widen(w_src_a[c_last]) <<< WIDTH);
        end
    end

    assign w_product           = r_acc[c_last];
    assign w_unused_product_hi = ^w_product[c_acc_w-1:2*WIDTH];

    always_comb begin
        w_result_sel = w_product[2*WIDTH-1:WIDTH];
        if (r_op[c_last] == c_op_mul) begin
            w_result_sel = w_product[WIDTH-1:0];
        end
    end

    // Control path: valids, output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
        end else begin
            if (flush) begin
                r_valid     <= '0;
                r_out_valid <= 1'b0;
            end else if (w_advance) begin
                r_valid[0] <= w_accept;
                for (int s = 1; s < c_stages; s++) begin
                    r_valid[s] <= r_valid[s-1];
                end
                r_out_valid <= r_valid[c_last];
            end
            // Only real results are loaded so bubbles never disturb the output.
            if (w_advance && r_valid[c_last]) begin
                r_out_result <= w_result_sel;
                r_out_tag    <= r_tag[c_last];
            end
        end
    end

    // Datapath: contents are don't-care under a bubble, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int s = 0; s < c_stages; s++) begin
                r_acc[s] <= w_acc_nxt[s];
                r_a[s]   <= w_src_a[s];
                r_b[s]   <= w_src_b[s];
                r_op[s]  <= w_src_op[s];
                r_tag[s] <= w_src_tag[s];
            end
        end
    end

    assign bus.in_ready   = w_advance;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_mul_unit
// Brief    : Scoreboard bench: one 32/4 unit for directed scenarios plus three
//            16-bit units (1, 2, 8 bits per stage) under random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_mul_unit;

    localparam int NCH      = 4;
    localparam int TAG_W    = 5;
    localparam int RAND_CYC = 6000;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NCH-1:0]   ch_valid, ch_oready, ch_flush;
    logic [NCH-1:0]   ch_iready, ch_ovalid;
    logic [1:0]       ch_op   [NCH];
    logic [31:0]      ch_a    [NCH];
    logic [31:0]      ch_b    [NCH];
    logic [TAG_W-1:0] ch_tag  [NCH];
    logic [31:0]      ch_res  [NCH];
    logic [TAG_W-1:0] ch_otag [NCH];

    int   n_checks;
    int   n_errors;
    bit   lat_mode;
    bit   end_req;
    bit   end_ack;
    exp_t q [NCH][$];

    function automatic int ch_width(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic int ch_stages(input int c);
        case (c)
            0:       return 8;
            1:       return 16;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            localparam int W   = (c == 0) ? 32 : 16;
            localparam int BPS = (c == 0) ? 4 : (c == 1) ? 1 : (c == 2) ? 2 : 8;

            pipelined_mul_unit_if #(.WIDTH(W), .TAG_W(TAG_W)) bus ();

            assign bus.in_valid  = ch_valid[c];
            assign bus.in_op     = ch_op[c];
            assign bus.in_a      = ch_a[c][W-1:0];
            assign bus.in_b      = ch_b[c][W-1:0];
            assign bus.in_tag    = ch_tag[c];
            assign bus.out_ready = ch_oready[c];
            assign ch_iready[c]  = bus.in_ready;
            assign ch_ovalid[c]  = bus.out_valid;
            assign ch_res[c]     = 32'(bus.out_result);
            assign ch_otag[c]    = bus.out_tag;

            pipelined_mul_unit #(
                .WIDTH          (W),
                .BITS_PER_STAGE (BPS),
                .TAG_W          (TAG_W)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .flush (ch_flush[c]),
                .bus   (bus.slave)
            );
        end
    endgenerate

    // Reference: exact integer product of the extended operands, then the
    // requested half.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [63:0] mask;
        longint      av;
        longint      bv;
        logic [63:0] p;
        mask = (64'd1 << w) - 64'd1;
        av   = longint'({32'd0, a & mask[31:0]});
        bv   = longint'({32'd0, b & mask[31:0]});
        if ((op == 2'b01 || op == 2'b10) && a[w-1]) av = av - (longint'(1) << w);
        if (op == 2'b01 && b[w-1])                   bv = bv - (longint'(1) << w);
        p = 64'(av * bv);
        if (op == 2'b00) return 32'(p & mask);
        return 32'((p >> w) & mask);
    endfunction

    function automatic logic [31:0] rand_operand(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return m;
            2:       return 32'd1 << (w - 1);
            3:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic check(input bit ok, input string name, input int c,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s ch%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        bit               prev_reset;
        bit [NCH-1:0]     prev_hold;
        bit [NCH-1:0]     prev_flush;
        logic [31:0]      prev_res [NCH];
        logic [TAG_W-1:0] prev_tag [NCH];
        int               cyc;
        n_checks   = 0;
        n_errors   = 0;
        end_ack    = 0;
        cyc        = 0;
        prev_reset = 0;
        prev_hold  = '0;
        prev_flush = '0;
        for (int c = 0; c < NCH; c++) begin
            prev_res[c] = '0;
            prev_tag[c] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                exp_t e;
                if (prev_reset) begin
                    check(ch_ovalid[c] == 1'b0, "reset_out_valid", c, 64'(ch_ovalid[c]), 64'd0);
                    check(ch_res[c] == 32'd0, "reset_out_result", c, 64'(ch_res[c]), 64'd0);
                    check(ch_otag[c] == '0, "reset_out_tag", c, 64'(ch_otag[c]), 64'd0);
                end else if (prev_hold[c] && !prev_flush[c]) begin
                    check(ch_ovalid[c] == 1'b1, "stall_valid", c, 64'(ch_ovalid[c]), 64'd1);
                    check(ch_res[c] == prev_res[c], "stall_result", c, 64'(ch_res[c]), 64'(prev_res[c]));
                    check(ch_otag[c] == prev_tag[c], "stall_tag", c, 64'(ch_otag[c]), 64'(prev_tag[c]));
                end
                check(ch_iready[c] == (!ch_ovalid[c] || ch_oready[c]), "in_ready", c,
                      64'(ch_iready[c]), 64'(!ch_ovalid[c] || ch_oready[c]));

                if (reset) begin
                    q[c].delete();
                end else begin
                    if (ch_ovalid[c] && ch_oready[c]) begin
                        check(q[c].size() != 0, "unexpected_out", c, 64'(ch_res[c]), 64'd0);
                        if (q[c].size() != 0) begin
                            e = q[c].pop_front();
                            check(ch_res[c] == e.res, "result", c, 64'(ch_res[c]), 64'(e.res));
                            check(ch_otag[c] == e.tag, "tag", c, 64'(ch_otag[c]), 64'(e.tag));
                            if (e.lat) begin
                                check(cyc - e.cyc - 1 == ch_stages(c), "latency", c,
                                      64'(cyc - e.cyc - 1), 64'(ch_stages(c)));
                            end
                        end
                    end
                    if (ch_flush[c]) begin
                        q[c].delete();
                    end else if (ch_valid[c] && ch_iready[c]) begin
                        e.res = ref_mul(ch_op[c], ch_a[c], ch_b[c], ch_width(c));
                        e.tag = ch_tag[c];
                        e.cyc = cyc;
                        e.lat = lat_mode;
                        q[c].push_back(e);
                    end
                end
                prev_hold[c]  = ch_ovalid[c] && !ch_oready[c];
                prev_flush[c] = ch_flush[c];
                prev_res[c]   = ch_res[c];
                prev_tag[c]   = ch_otag[c];
            end
            prev_reset = reset;
            if (end_req && !end_ack) begin
                for (int c = 0; c < NCH; c++) begin
                    check(q[c].size() == 0, "drain", c, 64'(q[c].size()), 64'd0);
                end
                end_ack = 1;
            end
        end
    end

    // Holds the op on the port until the edge that accepts it.
    task automatic issue(input int c, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        ch_valid[c] = 1'b1;
        ch_op[c]    = op;
        ch_a[c]     = a;
        ch_b[c]     = b;
        ch_tag[c]   = tag;
        while (!ch_iready[c] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : driver
        int pending;
        reset     = 1'b1;
        ch_valid  = '0;
        ch_flush  = '0;
        ch_oready = '1;
        lat_mode  = 0;
        end_req   = 0;
        for (int c = 0; c < NCH; c++) begin
            ch_op[c]  = 2'b00;
            ch_a[c]   = '0;
            ch_b[c]   = '0;
            ch_tag[c] = '0;
        end
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);

        // Single MUL with latency check.
        lat_mode = 1;
        issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        ch_valid[0] = 1'b0;
        wait_cycles(12);

        // Back-to-back high-half ops.
        issue(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4);
        issue(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        issue(0, 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 5'd7);
        ch_valid[0] = 1'b0;
        lat_mode    = 0;
        wait_cycles(12);

        // Fill the pipe, then stall the consumer with another op waiting.
        for (int i = 0; i < 8; i++) begin
            issue(0, 2'($urandom_range(0, 3)), rand_operand(32), rand_operand(32), 5'(i + 8));
        end
        ch_oready[0] = 1'b0;
        ch_op[0]     = 2'b11;
        ch_a[0]      = rand_operand(32);
        ch_b[0]      = rand_operand(32);
        ch_tag[0]    = 5'd20;
        wait_cycles(6);
        ch_valid[0]  = 1'b0;
        ch_oready[0] = 1'b1;
        wait_cycles(20);

        // Flush with four ops in flight and one offered.
        for (int i = 0; i < 4; i++) begin
            issue(0, 2'($urandom_range(0, 3)), rand_operand(32), rand_operand(32), 5'(i + 21));
        end
        ch_op[0]    = 2'b00;
        ch_a[0]     = 32'd12345;
        ch_tag[0]   = 5'd25;
        ch_flush[0] = 1'b1;
        wait_cycles(1);
        ch_flush[0] = 1'b0;
        lat_mode    = 1;
        issue(0, 2'b00, 32'd1234, 32'd5678, 5'd26);
        ch_valid[0] = 1'b0;
        lat_mode    = 0;
        wait_cycles(15);

        // Reset while a result is presented and three more are in flight.
        for (int i = 0; i < 4; i++) begin
            issue(0, 2'b11, rand_operand(32), rand_operand(32), 5'(i + 27));
        end
        ch_valid[0] = 1'b0;
        for (int n = 0; n < 20 && !ch_ovalid[0]; n++) wait_cycles(1);
        ch_oready[0] = 1'b0;
        reset        = 1'b1;
        wait_cycles(1);
        reset        = 1'b0;
        ch_oready[0] = 1'b1;
        wait_cycles(12);

        // Latency on the 16-bit configurations.
        lat_mode = 1;
        for (int c = 1; c < NCH; c++) begin
            ch_valid[c] = 1'b1;
            ch_op[c]    = 2'b01;
            ch_a[c]     = 32'h0000_8001;
            ch_b[c]     = 32'h0000_7FFF;
            ch_tag[c]   = 5'(c);
        end
        wait_cycles(1);
        ch_valid = '0;
        lat_mode = 0;
        wait_cycles(20);

        // Random regression on every configuration.
        for (int i = 0; i < RAND_CYC; i++) begin
            for (int c = 0; c < NCH; c++) begin
                ch_valid[c]  = ($urandom_range(0, 3) != 0);
                ch_op[c]     = 2'($urandom_range(0, 3));
                ch_a[c]      = rand_operand(ch_width(c));
                ch_b[c]      = rand_operand(ch_width(c));
                ch_tag[c]    = 5'($urandom);
                ch_oready[c] = ($urandom_range(0, 3) != 0);
            end
            ch_flush[0] = ($urandom_range(0, 99) == 0);
            wait_cycles(1);
        end
        ch_valid  = '0;
        ch_flush  = '0;
        ch_oready = '1;

        pending = 1;
        for (int n = 0; n < 200 && pending != 0; n++) begin
            wait_cycles(1);
            pending = 0;
            for (int c = 0; c < NCH; c++) pending += q[c].size();
        end
        end_req = 1;
        for (int n = 0; n < 10 && !end_ack; n++) wait_cycles(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
